// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types for the forwarding/hazard unit: register address width, forwarding
// select encodings and the pipeline stage records.
package fwd_hazard_unit_pkg;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10,
    FWD_PWB = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    reg_addr_t dst;
    logic      wr;
  } stage_rec_t;

  typedef struct packed {
    reg_addr_t  rs;
    reg_addr_t  rt;
    stage_rec_t rec;
    logic       ld;
  } ex_rec_t;

  // Register 0 is hardwired, so a write to it never produces a usable value.
  function automatic logic writes_reg(stage_rec_t r, reg_addr_t src);
    return r.wr && (r.dst != '0) && (r.dst == src);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request and forwarding/stall response bundle.
// The stall_cnt signal exists only when HAZ_STATS_EN is defined.
interface fwd_hazard_unit_if;
  import fwd_hazard_unit_pkg::*;

  logic      id_valid;
  reg_addr_t id_rs;
  reg_addr_t id_rt;
  reg_addr_t id_dst;
  logic      id_reg_write;
  logic      id_mem_read;
  logic      flush;
  logic      stall;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
`ifdef HAZ_STATS_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  modport master (
    output id_valid, id_rs, id_rt, id_dst, id_reg_write, id_mem_read, flush,
    input  stall, fwd_a_sel, fwd_b_sel
`ifdef HAZ_STATS_EN
    , stall_cnt
`endif
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_dst, id_reg_write, id_mem_read, flush,
    output stall, fwd_a_sel, fwd_b_sel
`ifdef HAZ_STATS_EN
    , stall_cnt
`endif
  );

endinterface

// File: rtl/fwd_hazard_unit_sel_cmp.sv
// Per-operand forwarding select: compares one EX source against the younger-to-older
// MEM/WB/PWB destination records and picks the newest match.
module fwd_sel_cmp
  import fwd_hazard_unit_pkg::*;
(
  input  reg_addr_t  src,
  input  stage_rec_t mem,
  input  stage_rec_t wb,
  input  stage_rec_t pwb,
  output fwd_sel_e   sel
);

  // NOTE: sel gets a default before any branch so no latch is inferred.
  always_comb begin
    sel = FWD_RF;
    if      (writes_reg(mem, src)) sel = FWD_MEM;
    else if (writes_reg(wb,  src)) sel = FWD_WB;
    else if (writes_reg(pwb, src)) sel = FWD_PWB;
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use stall unit tracking EX/MEM/WB/post-WB destinations.
// Define HAZ_STATS_EN to add the saturating stall_cnt statistics counter.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
(
  input logic               clk,
  input logic               rst,
  fwd_hazard_unit_if.slave  bus
);

  ex_rec_t    ex_q,  ex_d;
  stage_rec_t mem_q, mem_d;
  stage_rec_t wb_q,  wb_d;
  stage_rec_t pwb_q, pwb_d;
  logic       stall;
  fwd_sel_e   sel_a, sel_b;

  // A load still in EX cannot forward yet; a dependent in ID must wait one cycle.
  always_comb begin
    stall = ex_q.ld && bus.id_valid && !bus.flush &&
            (writes_reg(ex_q.rec, bus.id_rs) || writes_reg(ex_q.rec, bus.id_rt));
  end

  always_comb begin
    ex_d  = '0;
    mem_d = ex_q.rec;
    wb_d  = mem_q;
    pwb_d = wb_q;
    if (bus.id_valid && !stall && !bus.flush) begin
      ex_d.rs      = bus.id_rs;
      ex_d.rt      = bus.id_rt;
      ex_d.rec.dst = bus.id_dst;
      ex_d.rec.wr  = bus.id_reg_write;
      ex_d.ld      = bus.id_mem_read;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the pre-edge value of its predecessor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      pwb_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      pwb_q <= pwb_d;
    end
  end

  fwd_sel_cmp u_cmp_a (.src(ex_q.rs), .mem(mem_q), .wb(wb_q), .pwb(pwb_q), .sel(sel_a));
  fwd_sel_cmp u_cmp_b (.src(ex_q.rt), .mem(mem_q), .wb(wb_q), .pwb(pwb_q), .sel(sel_b));

  assign bus.stall     = stall;
  assign bus.fwd_a_sel = sel_a;
  assign bus.fwd_b_sel = sel_b;

`ifdef HAZ_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed vector table, reset/stall corner
// sequences, and randomized traffic against an instruction-level pipeline model.
module tb_fwd_hazard_unit;
  import fwd_hazard_unit_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fwd_hazard_unit_if bus ();

  fwd_hazard_unit dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs, rt, dst;
    logic       wr, ld, fl;
    logic       e_stall;
    logic [1:0] e_a, e_b;
  } vec_t;

  // Model: in-flight instructions by age; slot k is k stages past EX (0=EX .. 3=PWB).
  typedef struct {
    logic [4:0] rs, rt, dst;
    logic       wr, ld;
  } minst_t;

  minst_t      pipe [4];
  logic [15:0] m_cnt;

  function automatic vec_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] dst,
                              logic wr, logic ld, logic fl,
                              logic es, logic [1:0] ea, logic [1:0] eb);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.dst = dst; r.wr = wr; r.ld = ld; r.fl = fl;
    r.e_stall = es; r.e_a = ea; r.e_b = eb;
    return r;
  endfunction

  // Select code equals the age distance of the newest producer of src.
  function automatic logic [1:0] model_sel(logic [4:0] src);
    for (int k = 1; k <= 3; k++)
      if (pipe[k].wr && pipe[k].dst != 0 && pipe[k].dst == src) return 2'(k);
    return 2'd0;
  endfunction

  function automatic logic model_stall(vec_t v);
    if (!v.v || v.fl || !pipe[0].ld || !pipe[0].wr || pipe[0].dst == 0) return 1'b0;
    return (pipe[0].dst == v.rs) || (pipe[0].dst == v.rt);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) pipe[k] = '{default: '0};
    m_cnt = '0;
  endtask

  task automatic model_advance(vec_t v, logic stl);
    for (int k = 3; k > 0; k--) pipe[k] = pipe[k-1];
    pipe[0] = '{default: '0};
    if (v.v && !stl && !v.fl) begin
      pipe[0].rs = v.rs; pipe[0].rt = v.rt; pipe[0].dst = v.dst;
      pipe[0].wr = v.wr; pipe[0].ld = v.ld;
    end
    if (stl && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.id_valid     = v.v;
    bus.id_rs        = v.rs;
    bus.id_rt        = v.rt;
    bus.id_dst       = v.dst;
    bus.id_reg_write = v.wr;
    bus.id_mem_read  = v.ld;
    bus.flush        = v.fl;
  endtask

  // One cycle: drive at negedge, compare mid-low-phase, advance the model at posedge.
  task automatic step(vec_t v, bit use_tbl, string tag);
    logic       m_stall;
    logic [1:0] m_a, m_b;
    @(negedge clk);
    drive(v);
    #1;
    m_stall = model_stall(v);
    m_a     = model_sel(pipe[0].rs);
    m_b     = model_sel(pipe[0].rt);
    if (use_tbl) begin
      m_stall = v.e_stall; m_a = v.e_a; m_b = v.e_b;
    end
    check({tag, ".stall"}, 32'(bus.stall),     32'(m_stall));
    check({tag, ".fwd_a"}, 32'(bus.fwd_a_sel), 32'(m_a));
    check({tag, ".fwd_b"}, 32'(bus.fwd_b_sel), 32'(m_b));
`ifdef HAZ_STATS_EN
    check({tag, ".cnt"}, 32'(bus.stall_cnt), 32'(m_cnt));
`endif
    @(posedge clk);
    model_advance(v, model_stall(v));
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, ".stall"}, 32'(bus.stall),     32'd0);
    check({tag, ".fwd_a"}, 32'(bus.fwd_a_sel), 32'd0);
    check({tag, ".fwd_b"}, 32'(bus.fwd_b_sel), 32'd0);
`ifdef HAZ_STATS_EN
    check({tag, ".cnt"}, 32'(bus.stall_cnt), 32'd0);
`endif
  endtask

  task automatic do_reset(int cycles, string tag);
    @(negedge clk);
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (cycles) @(posedge clk);
    #1;
    check_idle_outputs(tag);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl [19];
  vec_t idle;
  vec_t lw5;
  vec_t dep5;
  vec_t rv;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);
    model_clear();

    //          v  rs  rt  dst wr ld fl  stall a      b
    tbl[0]  = mk(1, 1,  2,  3,  1, 0, 0, 0, 2'b00, 2'b00); // add $3
    tbl[1]  = mk(1, 3,  0,  7,  1, 0, 0, 0, 2'b00, 2'b00); // sub rs=3
    tbl[2]  = mk(1, 3,  9,  8,  1, 0, 0, 0, 2'b01, 2'b00); // sub in EX: MEM hit
    tbl[3]  = mk(1, 3,  3,  0,  0, 0, 0, 0, 2'b10, 2'b00); // consumer: WB hit
    tbl[4]  = mk(0, 0,  0,  0,  0, 0, 0, 0, 2'b11, 2'b11); // rs=rt=3: PWB hit
    tbl[5]  = mk(1, 1,  0,  5,  1, 1, 0, 0, 2'b00, 2'b00); // lw $5
    tbl[6]  = mk(1, 2,  5, 10,  1, 0, 0, 1, 2'b00, 2'b00); // load-use stall
    tbl[7]  = mk(1, 2,  5, 10,  1, 0, 0, 0, 2'b00, 2'b00); // held, no 2nd stall
    tbl[8]  = mk(0, 0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b10); // dependent gets WB
    tbl[9]  = mk(1, 0,  0,  0,  1, 1, 0, 0, 2'b00, 2'b00); // lw $0
    tbl[10] = mk(1, 0,  0, 11,  1, 0, 0, 0, 2'b00, 2'b00); // reader $0: no stall
    tbl[11] = mk(1, 0,  0, 12,  0, 0, 0, 0, 2'b00, 2'b00);
    tbl[12] = mk(1, 1,  1,  4,  1, 0, 0, 0, 2'b00, 2'b00); // add $4
    tbl[13] = mk(1, 2,  2,  4,  1, 0, 0, 0, 2'b00, 2'b00); // add $4 again
    tbl[14] = mk(1, 4,  4, 13,  1, 0, 0, 0, 2'b00, 2'b00); // reader rs=rt=4
    tbl[15] = mk(0, 0,  0,  0,  0, 0, 0, 0, 2'b01, 2'b01); // newest wins
    tbl[16] = mk(1, 1,  1,  6,  1, 1, 0, 0, 2'b00, 2'b00); // lw $6
    tbl[17] = mk(1, 6,  6, 14,  1, 0, 1, 0, 2'b00, 2'b00); // dependent + flush
    tbl[18] = mk(0, 0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b00); // EX holds bubble

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_held");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(idle, 1'b0, $sformatf("idle%0d", i));

    for (int i = 0; i < 19; i++) step(tbl[i], 1'b1, $sformatf("tbl%0d", i));

    // Three separate load-use hazards from a clean counter.
    do_reset(2, "reset2");
    lw5  = mk(1, 0, 0, 5, 1, 1, 0, 0, 0, 0);
    dep5 = mk(1, 5, 1, 9, 1, 0, 0, 0, 0, 0);
    for (int h = 0; h < 3; h++) begin
      step(lw5,  1'b0, $sformatf("haz%0d.lw", h));
      step(dep5, 1'b0, $sformatf("haz%0d.dep", h));
      step(dep5, 1'b0, $sformatf("haz%0d.held", h));
    end
`ifdef HAZ_STATS_EN
    @(negedge clk);
    drive(idle);
    #1;
    check("three_hazards.cnt", 32'(bus.stall_cnt), 32'd3);
`endif

    // Reset asserted in the middle of a stall cycle.
    step(lw5, 1'b0, "mid.lw");
    @(negedge clk);
    drive(dep5);
    #1;
    check("mid.stall_before", 32'(bus.stall), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_idle_outputs("mid.after_rst");
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(idle);

    for (int i = 0; i < 400; i++) begin
      rv.v  = ($urandom_range(0, 9) != 0);
      rv.rs = 5'($urandom_range(0, 3));
      rv.rt = 5'($urandom_range(0, 3));
      rv.dst = 5'($urandom_range(0, 3));
      rv.wr = ($urandom_range(0, 3) != 0);
      rv.ld = ($urandom_range(0, 2) == 0);
      rv.fl = ($urandom_range(0, 9) == 0);
      rv.e_stall = 1'b0; rv.e_a = 2'b00; rv.e_b = 2'b00;
      step(rv, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
